// File: rtl/oct_arb_pkg.sv
// ---------------------------------------------------------------------------
// oct_arb_pkg
//   Shared types and helpers for the 8-way round-robin arbiter.
//   - NUM_REQ / IDX_W : requester count and index width
//   - arb_state_t     : arbiter FSM state
//   - pick_t          : winner index plus found flag
//   - rr_pick()       : first set request bit at or above ptr, wrapping 7->0
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package oct_arb_pkg;

   localparam int NUM_REQ = 8;
   localparam int IDX_W   = 3;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   typedef struct packed {
      logic             found;
      logic [IDX_W-1:0] idx;
   } pick_t;

   // Walk the candidates from the highest offset down so the lowest offset
   // (closest to ptr) is the last writer and therefore wins. The 3-bit add
   // gives the 7->0 wrap for free.
   function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                     input logic [IDX_W-1:0]   ptr);
      pick_t            res;
      logic [IDX_W-1:0] cand;
      res = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         cand = ptr + IDX_W'(i);
         if (req[cand]) begin
            res.found = 1'b1;
            res.idx   = cand;
         end
      end
      return res;
   endfunction

endpackage

`default_nettype wire

// File: rtl/oct_onehot_idx.sv
// ---------------------------------------------------------------------------
// oct_onehot_idx
//   Combinational one-hot to binary encoder. All-zero input gives index 0.
//   Ports:
//     onehot_i [7:0] : one-hot (or zero) vector
//     idx_o    [2:0] : binary index of the set bit
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module oct_onehot_idx
   import oct_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] onehot_i,
   output logic [IDX_W-1:0]   idx_o
);

   // OR of the indices of all set bits; exact for one-hot, 0 for zero.
   always_comb begin
      idx_o = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx_o = idx_o | (onehot_i[i] ? IDX_W'(i) : '0);
      end
   end

endmodule

`default_nettype wire

// File: rtl/oct_rr_arbiter.sv
// ---------------------------------------------------------------------------
// oct_rr_arbiter
//   8-requester round-robin arbiter with registered one-hot grant that is
//   held until the holder drops its request. Release and re-grant happen on
//   the same edge when other requests are pending.
//   Ports:
//     clk       : rising-edge clock
//     rst       : synchronous active-high reset
//     req [7:0] : request vector
//     gnt [7:0] : registered one-hot grant or zero
//     gnt_idx   : binary index of gnt (0 when idle)
//     gnt_valid : a grant is active
//     rr_ptr    : current highest-priority index (debug)
//   Optional: define ARB_HOLD_TIMEOUT_EN to force a release after MAX_HOLD
//   consecutive grant cycles.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module oct_rr_arbiter
   import oct_arb_pkg::*;
#(
   parameter int MAX_HOLD = 16
)(
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   gnt_idx,
   output logic               gnt_valid,
   output logic [IDX_W-1:0]   rr_ptr
);

   if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_max_hold_range
      $error("oct_rr_arbiter: MAX_HOLD must be within 1..255");
   end

   arb_state_t         state_q, state_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]   w_holder;
   logic               w_timeout;
   pick_t              w_pick;

`ifdef ARB_HOLD_TIMEOUT_EN
   logic [7:0] cnt_q, cnt_d;
   assign w_timeout = (cnt_q == 8'(MAX_HOLD - 1));
`else
   assign w_timeout = 1'b0;
`endif

   oct_onehot_idx u_enc (
      .onehot_i (gnt_q),
      .idx_o    (w_holder)
   );

   // rr_ptr already sits one past the current holder, so searching from it
   // on release puts the holder at lowest priority.
   assign w_pick = rr_pick(req, rr_ptr_q);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         gnt_q    <= '0;
         rr_ptr_q <= '0;
`ifdef ARB_HOLD_TIMEOUT_EN
         cnt_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         rr_ptr_q <= rr_ptr_d;
`ifdef ARB_HOLD_TIMEOUT_EN
         cnt_q    <= cnt_d;
`endif
      end
   end

   // Next-state logic
   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      rr_ptr_d = rr_ptr_q;
`ifdef ARB_HOLD_TIMEOUT_EN
      cnt_d    = cnt_q;
`endif
      if (state_q == IDLE || !req[w_holder] || w_timeout) begin
         // Arbitrate: from idle, or on release by the holder
         if (w_pick.found) begin
            state_d  = GRANT;
            gnt_d    = NUM_REQ'(1) << w_pick.idx;
            rr_ptr_d = w_pick.idx + IDX_W'(1);
`ifdef ARB_HOLD_TIMEOUT_EN
            cnt_d    = '0;
`endif
         end else begin
            state_d = IDLE;
            gnt_d   = '0;
         end
      end else begin
`ifdef ARB_HOLD_TIMEOUT_EN
         cnt_d = cnt_q + 8'd1;
`endif
      end
   end

   // Outputs (all derived from registers only)
   always_comb begin
      gnt       = gnt_q;
      gnt_idx   = w_holder;
      gnt_valid = (state_q == GRANT);
      rr_ptr    = rr_ptr_q;
   end

endmodule

`default_nettype wire

// File: tb/tb_oct_rr_arbiter.sv
`default_nettype none

module tb_oct_rr_arbiter;
   localparam int MH = 4;
`ifdef ARB_HOLD_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] req = 8'h00;
   logic [7:0] gnt;
   logic [2:0] gnt_idx;
   logic       gnt_valid;
   logic [2:0] rr_ptr;

   int checks = 0;
   int errors = 0;

   // Reference model: holder (-1 = none), priority pointer, hold count
   int m_hold = -1;
   int m_ptr  = 0;
   int m_cnt  = 0;

   oct_rr_arbiter #(.MAX_HOLD(MH)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid),
      .rr_ptr    (rr_ptr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void model_step(input logic [7:0] r, input logic rs);
      bit release_now;
      if (rs) begin
         m_hold = -1; m_ptr = 0; m_cnt = 0;
         return;
      end
      release_now = (m_hold < 0) || !r[m_hold] || (TO_EN && m_cnt == MH - 1);
      if (!release_now) begin
         m_cnt++;
      end else begin
         m_hold = -1;
         for (int i = 0; i < 8; i++) begin
            int j;
            j = (m_ptr + i) % 8;
            if (r[j]) begin
               m_hold = j;
               m_ptr  = (j + 1) % 8;
               m_cnt  = 0;
               break;
            end
         end
      end
   endfunction

   // Apply req for one edge, advance the model, compare 1 time unit later
   task automatic step(input logic [7:0] r);
      req = r;
      @(posedge clk);
      model_step(r, rst);
      #1;
      chk("gnt",       {24'd0, gnt},     (m_hold < 0) ? 32'd0 : (32'd1 << m_hold));
      chk("gnt_idx",   {29'd0, gnt_idx}, (m_hold < 0) ? 32'd0 : 32'(m_hold));
      chk("gnt_valid", {31'd0, gnt_valid}, {31'd0, m_hold >= 0});
      chk("rr_ptr",    {29'd0, rr_ptr},  32'(m_ptr));
      chk("onehot",    32'($countones(gnt) <= 1), 32'd1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(8'h00);
      step(8'h00);
      rst = 1'b0;
   endtask

   initial begin
      logic [7:0] r;

      // Reset state
      do_reset();
      chk("reset_gnt", {24'd0, gnt}, 32'd0);
      chk("reset_ptr", {29'd0, rr_ptr}, 32'd0);

      // Single request to 2
      step(8'b0000_0100);
      chk("single_gnt", {24'd0, gnt}, 32'h04);
      chk("single_idx", {29'd0, gnt_idx}, 32'd2);
      chk("single_ptr", {29'd0, rr_ptr}, 32'd3);

      // All requesting; each holder drops for one cycle after two cycles
      do_reset();
      step(8'hFF);
      for (int g = 0; g < 9; g++) begin
         chk("rotate_idx", {29'd0, gnt_idx}, 32'(g % 8));
         if (g == 7) chk("wrap_ptr", {29'd0, rr_ptr}, 32'd0);
         step(8'hFF);
         step(8'hFF & ~(8'h01 << (g % 8)));
      end

      // Holder 5 drops while 1 and 6 wait: back-to-back move to 6
      do_reset();
      step(8'h20);
      step(8'h62);
      chk("hold5_gnt", {24'd0, gnt}, 32'h20);
      step(8'h42);
      chk("b2b_gnt", {24'd0, gnt}, 32'h40);
      chk("b2b_valid", {31'd0, gnt_valid}, 32'd1);

      // Holder 3 releases with nothing pending
      do_reset();
      step(8'h08);
      step(8'h00);
      chk("rel_gnt", {24'd0, gnt}, 32'd0);
      chk("rel_valid", {31'd0, gnt_valid}, 32'd0);
      chk("rel_ptr", {29'd0, rr_ptr}, 32'd4);

      // Reset while holder is 7
      do_reset();
      step(8'h80);
      chk("hold7_gnt", {24'd0, gnt}, 32'h80);
      rst = 1'b1;
      step(8'h80);
      chk("midrst_gnt", {24'd0, gnt}, 32'd0);
      chk("midrst_ptr", {29'd0, rr_ptr}, 32'd0);
      rst = 1'b0;
      step(8'h81);
      chk("after_rst_gnt", {24'd0, gnt}, 32'h01);

`ifdef ARB_HOLD_TIMEOUT_EN
      // Constant req=0x03: grant alternates every MH cycles
      do_reset();
      step(8'h03);
      chk("to_first", {29'd0, gnt_idx}, 32'd0);
      for (int i = 0; i < MH; i++) step(8'h03);
      chk("to_second", {29'd0, gnt_idx}, 32'd1);
      for (int i = 0; i < MH; i++) step(8'h03);
      chk("to_third", {29'd0, gnt_idx}, 32'd0);
`endif

      // Randomized phase: mostly sticky requests, occasional reset
      do_reset();
      r = 8'(($urandom));
      for (int n = 0; n < 400; n++) begin
         rst = ($urandom_range(0, 63) == 0);
         if ($urandom_range(0, 3) == 0) r = r ^ (8'h01 << $urandom_range(0, 7));
         if ($urandom_range(0, 31) == 0) r = 8'(($urandom));
         step(r);
      end
      rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
